// File: rtl/heap_sram_arbiter.sv
// Two-requester arbiter/sequencer in front of the byte-wide tree_sram.
// Word writes become four byte writes; reads return the little-endian word at addr.
module heap_sram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_wword,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_wword,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [31:0]       rdata,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_d,
  input  logic [31:0]       sram_q
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_CAP   = 2'd2,
    WR       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              wword_q, wword_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        k_q, k_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              sram_wen_q, sram_wen_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [7:0]        sram_byte_q, sram_byte_d;

  logic              grant_any;
  logic              grant_port;
  logic              sel_we;
  logic              sel_wword;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              wr_last;
  logic [1:0]        k_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      wword_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      k_q         <= 2'd0;
      rr_ptr_q    <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      rdata_q     <= '0;
      sram_wen_q  <= 1'b0;
      sram_addr_q <= '0;
      sram_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      wword_q     <= wword_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      rr_ptr_q    <= rr_ptr_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      rdata_q     <= rdata_d;
      sram_wen_q  <= sram_wen_d;
      sram_addr_q <= sram_addr_d;
      sram_byte_q <= sram_byte_d;
    end
  end

  // rr_ptr_q names the port favoured on the next conflict.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (m0_req && m1_req) begin
        grant_any  = 1'b1;
        grant_port = (RR_EN != 0) ? rr_ptr_q : 1'b0;
      end else if (m0_req) begin
        grant_any  = 1'b1;
        grant_port = 1'b0;
      end else if (m1_req) begin
        grant_any  = 1'b1;
        grant_port = 1'b1;
      end
    end

    sel_we    = grant_port ? m1_we    : m0_we;
    sel_wword = grant_port ? m1_wword : m0_wword;
    sel_addr  = grant_port ? m1_addr  : m0_addr;
    sel_wdata = grant_port ? m1_wdata : m0_wdata;
    wr_last   = !wword_q || (k_q == 2'd3);
    k_nxt     = k_q + 2'd1;

    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    wword_d  = wword_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    k_d      = k_q;
    rr_ptr_d = rr_ptr_q;

    case (state_q)
      IDLE: begin
        k_d = 2'd0;
        if (grant_any) begin
          port_d   = grant_port;
          we_d     = sel_we;
          wword_d  = sel_wword;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          rr_ptr_d = ~grant_port;
          state_d  = sel_we ? WR : RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_CAP;
      RD_CAP:   state_d = IDLE;
      WR: begin
        k_d = k_nxt;
        if (wr_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM bus values are registered one edge ahead of the state they belong to.
  always_comb begin
    m0_gnt      = grant_any && !grant_port;
    m1_gnt      = grant_any && grant_port;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    rdata_d     = rdata_q;
    sram_wen_d  = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_byte_d = sram_byte_q;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          sram_addr_d = sel_addr;
          if (sel_we) begin
            sram_wen_d  = 1'b1;
            sram_byte_d = sel_wdata[7:0];
          end
        end
      end
      RD_CAP: begin
        rdata_d  = sram_q;
        m0_ack_d = !port_q;
        m1_ack_d = port_q;
      end
      WR: begin
        if (wr_last) begin
          m0_ack_d = !port_q;
          m1_ack_d = port_q;
        end else begin
          sram_wen_d  = 1'b1;
          sram_addr_d = addr_q + ADDR_W'(k_nxt);
          sram_byte_d = wdata_q[{k_nxt, 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign rdata     = rdata_q;
  assign sram_wen  = sram_wen_q;
  assign sram_addr = sram_addr_q;
  assign sram_d    = {24'b0, sram_byte_q};

endmodule

// File: tb/tb_heap_sram_arbiter.sv
// Randomised and directed bench for heap_sram_arbiter with a byte-wide SRAM model
// and a scoreboard fed by a memory-level reference model.
module tb_heap_sram_arbiter;

  localparam int RR = 1;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_wword, m0_gnt, m0_ack;
  logic [15:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m1_req, m1_we, m1_wword, m1_gnt, m1_ack;
  logic [15:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] rdata;
  logic        sram_wen;
  logic [15:0] sram_addr;
  logic [31:0] sram_d;
  logic [31:0] sram_q;

  logic        fp_m0_req, fp_m1_req, fp_m0_gnt, fp_m1_gnt, fp_m0_ack, fp_m1_ack;
  logic [31:0] fp_rdata, fp_sram_d;
  logic        fp_sram_wen;
  logic [15:0] fp_sram_addr;

  heap_sram_arbiter #(.ADDR_W(16), .RR_EN(RR)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wword(m0_wword), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wword(m1_wword), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack),
    .rdata(rdata), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .sram_q(sram_q)
  );

  heap_sram_arbiter #(.ADDR_W(16), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(fp_m0_req), .m0_we(1'b0), .m0_wword(1'b0), .m0_addr(16'h0000),
    .m0_wdata(32'h0), .m0_gnt(fp_m0_gnt), .m0_ack(fp_m0_ack),
    .m1_req(fp_m1_req), .m1_we(1'b0), .m1_wword(1'b0), .m1_addr(16'h0004),
    .m1_wdata(32'h0), .m1_gnt(fp_m1_gnt), .m1_ack(fp_m1_ack),
    .rdata(fp_rdata), .sram_wen(fp_sram_wen), .sram_addr(fp_sram_addr), .sram_d(fp_sram_d),
    .sram_q(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide SRAM: write d[7:0] at addr, q is the registered little-endian word.
  logic [7:0]  mem [65536];
  logic [15:0] sa1, sa2, sa3;
  assign sa1 = sram_addr + 16'd1;
  assign sa2 = sram_addr + 16'd2;
  assign sa3 = sram_addr + 16'd3;
  initial for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_d[7:0];
    sram_q <= {mem[sa3], mem[sa2], mem[sa1], mem[sram_addr]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents plus expected acks and SRAM byte writes.
  typedef struct { logic port; logic rd; logic [31:0] data; int due; } ack_exp_t;
  typedef struct { logic [15:0] a; logic [7:0] d; int due; } wr_exp_t;
  logic [7:0] ref_mem [65536];
  ack_exp_t   exp_q[$];
  wr_exp_t    wq[$];
  int         busy_until = 0;
  logic       last_gnt = 1'b1;
  initial for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

  logic        w, we_s, ww_s;
  logic [15:0] ga, ak;
  logic [31:0] gd;
  logic [1:0]  exp_g, exp_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      wq.delete();
      busy_until = 0;
      last_gnt   = 1'b1;
      chk("gnt_in_reset", {62'b0, m1_gnt, m0_gnt}, 64'd0);
    end else begin
      exp_g = 2'b00;
      w     = 1'b0;
      if (cyc >= busy_until && (m0_req || m1_req)) begin
        if (m0_req && m1_req) w = (RR != 0) ? ~last_gnt : 1'b0;
        else                  w = m1_req;
        exp_g = w ? 2'b10 : 2'b01;
      end
      if (exp_g != 2'b00 || m0_gnt || m1_gnt) chk("gnt", {62'b0, m1_gnt, m0_gnt}, {62'b0, exp_g});
      if (exp_g != 2'b00) begin
        we_s = w ? m1_we : m0_we;
        ww_s = w ? m1_wword : m0_wword;
        ga   = w ? m1_addr : m0_addr;
        gd   = w ? m1_wdata : m0_wdata;
        last_gnt = w;
        if (!we_s) begin
          exp_q.push_back('{w, 1'b1, {ref_mem[16'(ga + 16'd3)], ref_mem[16'(ga + 16'd2)],
                                       ref_mem[16'(ga + 16'd1)], ref_mem[ga]}, cyc + 3});
          busy_until = cyc + 3;
        end else if (!ww_s) begin
          ref_mem[ga] = gd[7:0];
          wq.push_back('{ga, gd[7:0], cyc + 1});
          exp_q.push_back('{w, 1'b0, 32'h0, cyc + 2});
          busy_until = cyc + 2;
        end else begin
          for (int k = 0; k < 4; k++) begin
            ak = ga + 16'(k);
            ref_mem[ak] = gd[8*k +: 8];
            wq.push_back('{ak, gd[8*k +: 8], cyc + 1 + k});
          end
          exp_q.push_back('{w, 1'b0, 32'h0, cyc + 5});
          busy_until = cyc + 5;
        end
      end

      exp_a = 2'b00;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) exp_a = exp_q[0].port ? 2'b10 : 2'b01;
      if (exp_a != 2'b00 || m0_ack || m1_ack) begin
        chk("ack", {62'b0, m1_ack, m0_ack}, {62'b0, exp_a});
        if (exp_a != 2'b00) begin
          if (exp_q[0].rd) chk("rdata", {32'b0, rdata}, {32'b0, exp_q[0].data});
          void'(exp_q.pop_front());
        end
      end

      if (wq.size() > 0 && wq[0].due == cyc) begin
        chk("sram_wen", {63'b0, sram_wen}, 64'd1);
        chk("sram_addr", {48'b0, sram_addr}, {48'b0, wq[0].a});
        chk("sram_d", {32'b0, sram_d}, {56'b0, wq[0].d});
        void'(wq.pop_front());
      end else if (sram_wen) begin
        chk("sram_wen_spurious", {63'b0, sram_wen}, 64'd0);
      end
    end
  end

  task automatic issue(input bit p, input bit we, input bit ww, input logic [15:0] a,
                       input logic [31:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (p) begin m1_req = 1'b1; m1_we = we; m1_wword = ww; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = 1'b1; m0_we = we; m0_wword = ww; m0_addr = a; m0_wdata = d; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = p ? m1_gnt : m0_gnt;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt_timeout: port %0d got no gnt, required one within 200 cycles", p);
    end
    @(posedge clk); #1;
    if (p) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (wq.size() == 0) && (cyc >= busy_until);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got %0d outstanding acks, required 0", exp_q.size());
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic rand_port(input bit p, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                      : 16'($urandom_range(0, 63));
      issue(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  logic [7:0] save2, save3;
  int         fp_c0, fp_c1;
  bit         fp_got;

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_wword = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_wword = 1'b0; m1_addr = '0; m1_wdata = '0;
    fp_m0_req = 1'b0; fp_m1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rdata", {32'b0, rdata}, 64'd0);
    chk("reset_sram_addr", {48'b0, sram_addr}, 64'd0);
    chk("reset_sram_d", {32'b0, sram_d}, 64'd0);
    chk("reset_sram_wen", {63'b0, sram_wen}, 64'd0);
    chk("reset_acks", {62'b0, m1_ack, m0_ack}, 64'd0);

    issue(0, 1'b1, 1'b1, 16'h0010, 32'hA1B2C3D4); wait_idle();
    issue(1, 1'b0, 1'b0, 16'h0010, 32'h0);        wait_idle();

    reset_pulse();
    fork
      begin issue(0, 1'b0, 1'b0, 16'h0000, 32'h0); issue(0, 1'b0, 1'b0, 16'h0008, 32'h0); end
      issue(1, 1'b0, 1'b0, 16'h0004, 32'h0);
    join
    wait_idle();

    issue(0, 1'b1, 1'b1, 16'h0020, 32'h55667788); wait_idle();
    issue(1, 1'b1, 1'b0, 16'h0021, 32'h000000FF); wait_idle();
    issue(0, 1'b0, 1'b0, 16'h0020, 32'h0);        wait_idle();

    issue(1, 1'b1, 1'b1, 16'hFFFE, 32'h11223344); wait_idle();
    issue(0, 1'b0, 1'b0, 16'hFFFC, 32'h0);        wait_idle();
    issue(1, 1'b0, 1'b0, 16'h0000, 32'h0);        wait_idle();

    // Abort a word write with reset while its second byte is on the bus.
    issue(0, 1'b1, 1'b1, 16'h0100, 32'hDEADBEEF); wait_idle();
    save2 = ref_mem[16'h0102];
    save3 = ref_mem[16'h0103];
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_wword = 1'b1; m0_addr = 16'h0100; m0_wdata = 32'h11223344;
    @(negedge clk);
    chk("abort_gnt", {63'b0, m0_gnt}, 64'd1);
    @(posedge clk); #1; m0_req = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    ref_mem[16'h0102] = save2;
    ref_mem[16'h0103] = save3;
    @(negedge clk);
    chk("abort_wen_off", {63'b0, sram_wen}, 64'd0);
    chk("abort_no_ack", {62'b0, m1_ack, m0_ack}, 64'd0);
    fork
      issue(0, 1'b0, 1'b0, 16'h0100, 32'h0);
      issue(1, 1'b0, 1'b0, 16'h0102, 32'h0);
    join
    wait_idle();

    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join
    wait_idle();

    // Fixed-priority instance: m0 holding req continuously starves m1.
    @(posedge clk); #1;
    fp_m0_req = 1'b1;
    fp_m1_req = 1'b1;
    fp_c0 = 0;
    fp_c1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fp_m0_gnt) fp_c0++;
      if (fp_m1_gnt) fp_c1++;
    end
    chk("fp_m0_grants", 64'(fp_c0), 64'd10);
    chk("fp_m1_grants", 64'(fp_c1), 64'd0);
    @(posedge clk); #1;
    fp_m0_req = 1'b0;
    fp_got = 1'b0;
    for (int i = 0; i < 10 && !fp_got; i++) begin
      @(negedge clk);
      fp_got = fp_m1_gnt;
    end
    chk("fp_m1_after_release", {63'b0, fp_got}, 64'd1);
    @(posedge clk); #1;
    fp_m1_req = 1'b0;
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
